// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// default address/data widths also used by the instruction memory.
package instr_fetch_pkg;
    localparam int IF_AWIDTH_DEF = 15;
    localparam int IF_DWIDTH_DEF = 11;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter used for the optional fetch stall counter.
// Only built when INSTR_FETCH_STALL_CNT_EN is defined.
`ifdef INSTR_FETCH_STALL_CNT_EN
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands words
// to the decoder over valid/ready. Optional stall counter: INSTR_FETCH_STALL_CNT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                AWIDTH   = IF_AWIDTH_DEF,
    parameter int                DWIDTH   = IF_DWIDTH_DEF,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    input  logic              jump_en,
`ifdef INSTR_FETCH_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    input  logic [AWIDTH-1:0] jump_addr
);
    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_pc;
    logic [DWIDTH-1:0] r_instr;
    logic [AWIDTH-1:0] r_instr_pc;
    logic              w_fetch;

    // halt is the only input allowed to gate the read strobe.
    assign w_fetch  = (r_state == ST_FETCH) && !halt;
    assign mem_rd   = w_fetch;
    assign mem_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (jump_en) begin
            // Redirect wins; a held word is dropped and this cycle's read ignored.
            r_state <= ST_FETCH;
            r_pc    <= jump_addr;
        end else if (w_fetch) begin
            r_instr    <= mem_data;
            r_instr_pc <= r_pc;
            r_pc       <= r_pc + AWIDTH'(1);
            r_state    <= ST_HOLD;
        end else if ((r_state == ST_HOLD) && instr_ready) begin
            r_state <= ST_FETCH;
        end
    end

    assign instr_valid = (r_state == ST_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

`ifdef INSTR_FETCH_STALL_CNT_EN
    logic w_stall;
    assign w_stall = (r_state == ST_HOLD) && !instr_ready;

    sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall),
        .count (stall_cnt)
    );
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a combinational memory model.
// Stall counter checks are built when INSTR_FETCH_STALL_CNT_EN is defined.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        mem_rd;
    logic [14:0] mem_addr;
    logic [10:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [10:0] instr;
    logic [14:0] instr_pc;
    logic        jump_en;
    logic [14:0] jump_addr;
`ifdef INSTR_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [10:0] word_at(input logic [14:0] a);
        return a[10:0] ^ 11'h5A5 ^ {7'd0, a[14:11]};
    endfunction

    assign mem_data = word_at(mem_addr);

    instr_fetch #(
        .AWIDTH   (15),
        .DWIDTH   (11),
        .RESET_PC (15'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .jump_en     (jump_en),
`ifdef INSTR_FETCH_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .jump_addr   (jump_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [14:0] a);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".pc"}, 32'(instr_pc), 32'(a));
        check({tag, ".instr"}, 32'(instr), 32'(word_at(a)));
        check({tag, ".rd"}, 32'(mem_rd), 32'd0);
    endtask

    task automatic check_fetch(input string tag, input logic [14:0] a);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".rd"}, 32'(mem_rd), 32'd1);
        check({tag, ".addr"}, 32'(mem_addr), 32'(a));
    endtask

    initial begin
        rst_n       = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = '0;
        #3;
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.rd", 32'(mem_rd), 32'd1);
        check("rst.addr", 32'(mem_addr), 32'd0);
        check("rst.instr", 32'(instr), 32'd0);
        check("rst.pc", 32'(instr_pc), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Streaming with ready tied high: one word every other cycle.
        for (int i = 0; i < 3; i++) begin
            check_fetch($sformatf("stream%0d.f", i), 15'(i));
            step();
            check_word($sformatf("stream%0d.w", i), 15'(i));
            if (i < 2) step();
        end

        // Decoder stalls for five cycles on word 2.
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_word($sformatf("stall%0d", i), 15'd2);
        end
`ifdef INSTR_FETCH_STALL_CNT_EN
        check("stall.cnt5", 32'(stall_cnt), 32'd5);
`endif

        // Jump while holding an unaccepted word: it is dropped, then PC wraps.
        jump_en   = 1'b1;
        jump_addr = 15'h7FFF;
        step();
        jump_en     = 1'b0;
        instr_ready = 1'b1;
        check_fetch("jmp.f", 15'h7FFF);
        step();
        check_word("jmp.w", 15'h7FFF);
        step();
        check_fetch("wrap.f", 15'h0000);
        step();
        check_word("wrap.w", 15'h0000);
`ifdef INSTR_FETCH_STALL_CNT_EN
        check("stall.cnt6", 32'(stall_cnt), 32'd6);
`endif

        // Halt in FETCH: no reads, no words, PC held.
        step();
        halt = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("halt%0d.rd", i), 32'(mem_rd), 32'd0);
            check($sformatf("halt%0d.valid", i), 32'(instr_valid), 32'd0);
            check($sformatf("halt%0d.addr", i), 32'(mem_addr), 32'd1);
            step();
        end
        halt = 1'b0;
        #1;
        check_fetch("unhalt.f", 15'd1);
        step();
        check_word("unhalt.w", 15'd1);

        // Asynchronous reset between edges while holding a word.
        instr_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(instr_valid), 32'd0);
        check("arst.rd", 32'(mem_rd), 32'd1);
        check("arst.addr", 32'(mem_addr), 32'd0);
        check("arst.pc", 32'(instr_pc), 32'd0);
`ifdef INSTR_FETCH_STALL_CNT_EN
        check("arst.cnt", 32'(stall_cnt), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check_word("postrst.w", 15'd0);

        // Jump together with ready: held word delivered, next from target.
        instr_ready = 1'b1;
        jump_en     = 1'b1;
        jump_addr   = 15'h0123;
        step();
        jump_en = 1'b0;
        check_fetch("jmprdy.f", 15'h0123);
        step();
        check_word("jmprdy.w", 15'h0123);

        // halt does not block delivery of a held word.
        halt = 1'b1;
        step();
        check("halthold.valid", 32'(instr_valid), 32'd0);
        check("halthold.rd", 32'(mem_rd), 32'd0);
        check("halthold.addr", 32'(mem_addr), 32'h0124);
        halt = 1'b0;
        step();
        check_word("halthold.w", 15'h0124);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
